// File: rtl/conv_enc_pkg.sv
// Shared constants, types and parity helper for the rate-1/2 convolutional codec.
// Used by both the encoder and the Viterbi decoder's branch-metric logic.
package conv_enc_pkg;

  localparam int ENC_K    = 3;
  localparam int ENC_KMAX = 32;

  localparam logic [ENC_K-1:0] ENC_G0 = 3'b111;
  localparam logic [ENC_K-1:0] ENC_G1 = 3'b101;

  typedef logic [ENC_K-2:0] enc_state_t;
  typedef logic [1:0]       enc_sym_t;

  // Operands are zero-extended to ENC_KMAX so any constraint length up to 32 can share this helper.
  function automatic logic parity_f(input logic [ENC_KMAX-1:0] window,
                                    input logic [ENC_KMAX-1:0] gen);
    return ^(window & gen);
  endfunction

endpackage

// File: rtl/conv_enc_parity.sv
// Combinational window -> code symbol mapper {parity(G0), parity(G1)}.
// Also instantiated by the decoder to build its expected-symbol table.
module conv_enc_parity
  import conv_enc_pkg::*;
#(
  parameter int             K  = ENC_K,
  parameter logic [K-1:0]   G0 = K'(ENC_G0),
  parameter logic [K-1:0]   G1 = K'(ENC_G1)
) (
  input  logic [K-1:0] i_window,
  output logic [1:0]   o_sym
);

  logic [ENC_KMAX-1:0] w_win;
  logic [ENC_KMAX-1:0] w_g0;
  logic [ENC_KMAX-1:0] w_g1;

  assign w_win = ENC_KMAX'(i_window);
  assign w_g0  = ENC_KMAX'(G0);
  assign w_g1  = ENC_KMAX'(G1);

  assign o_sym = {parity_f(w_win, w_g0), parity_f(w_win, w_g1)};

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder, one serial bit in, one registered 2-bit symbol out.
// Optional zero-tail flushing after a falling enable_i is built when ENC_TAIL_EN is defined.
module conv_encoder
  import conv_enc_pkg::*;
#(
  parameter int           K  = ENC_K,
  parameter logic [K-1:0] G0 = K'(ENC_G0),
  parameter logic [K-1:0] G1 = K'(ENC_G1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       valid_o,
  output logic [1:0] d_out
);

  logic [K-2:0] r_state;
  logic [1:0]   r_sym;
  logic         r_valid;

  logic         w_bit;
  logic         w_encode;
  logic [K-1:0] w_window;
  logic [1:0]   w_sym;

`ifdef ENC_TAIL_EN
  localparam int TW = (K > 2) ? $clog2(K) : 1;

  logic          r_en_prev;
  logic [TW-1:0] r_tail_cnt;
  logic          w_tail_start;
  logic          w_tail_cont;

  // The first low-enable edge is itself tail cycle 1; r_tail_cnt holds the cycles still to go.
  assign w_tail_start = !enable_i && r_en_prev;
  assign w_tail_cont  = !enable_i && !r_en_prev && (r_tail_cnt != '0);
  assign w_encode     = enable_i || w_tail_start || w_tail_cont;
  assign w_bit        = enable_i && d_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_prev  <= 1'b0;
      r_tail_cnt <= '0;
    end else begin
      r_en_prev <= enable_i;
      if (enable_i) begin
        r_tail_cnt <= '0;
      end else if (w_tail_start) begin
        r_tail_cnt <= TW'(K - 2);
      end else if (w_tail_cont) begin
        r_tail_cnt <= r_tail_cnt - TW'(1);
      end
    end
  end
`else
  assign w_encode = enable_i;
  assign w_bit    = d_in;
`endif

  // Newest past bit sits in r_state[K-2], directly below the incoming bit.
  assign w_window = {w_bit, r_state};

  conv_enc_parity #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_parity (
    .i_window (w_window),
    .o_sym    (w_sym)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_sym   <= 2'b00;
      r_valid <= 1'b0;
    end else if (w_encode) begin
      r_state <= w_window[K-1:1];
      r_sym   <= w_sym;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign d_out   = r_sym;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder (K=3, generators 7,5): vector table, corner sequences,
// and a randomized run against a queue-based scoreboard. Honors ENC_TAIL_EN like the RTL.
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_i;
  logic       d_in;
  logic       valid_o;
  logic [1:0] d_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable_i),
    .d_in     (d_in),
    .valid_o  (valid_o),
    .d_out    (d_out)
  );

  typedef struct {
    logic       r;
    logic       en;
    logic       d;
    logic       exp_v;
    logic [1:0] exp_sym;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] sb[$];

  // Reference model state: m_s[1] is the newest past bit.
  logic [1:0] m_s;
  logic [1:0] m_sym;
  logic       m_v;
  logic       m_prev;
`ifdef ENC_TAIL_EN
  int         m_tail;
`endif

  function automatic void add(input logic r, input logic en, input logic d,
                              input logic v, input logic [1:0] s, input string n);
    vec_t x;
    x.r = r; x.en = en; x.d = d; x.exp_v = v; x.exp_sym = s; x.name = n;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic d);
    rst = r; enable_i = en; d_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input logic r, input logic en, input logic d,
                     input logic v, input logic [1:0] s, input string n);
    step(r, en, d);
    check({n, "_valid"}, 32'(valid_o), 32'(v));
    check({n, "_sym"}, 32'(d_out), 32'(s));
    $display("%s: rst=%b en=%b d=%b -> valid=%b d_out=%b", n, r, en, d, valid_o, d_out);
  endtask

  task automatic model_step(input logic r, input logic e, input logic d);
    logic b;
    logic enc;
    if (r) begin
      m_s = 2'b00; m_sym = 2'b00; m_v = 1'b0; m_prev = 1'b0;
`ifdef ENC_TAIL_EN
      m_tail = 0;
`endif
    end else begin
      b   = e & d;
      enc = e;
`ifdef ENC_TAIL_EN
      if (e) m_tail = 0;
      else if (m_prev) begin enc = 1'b1; m_tail = 1; end
      else if (m_tail > 0) begin enc = 1'b1; m_tail--; end
`endif
      if (enc) begin
        m_sym = {b ^ m_s[1] ^ m_s[0], b ^ m_s[0]};
        m_s   = {b, m_s[1]};
        m_v   = 1'b1;
        sb.push_back(m_sym);
      end else begin
        m_v = 1'b0;
      end
      m_prev = e;
    end
  endtask

  initial begin
    logic [9:0]  bits;
    logic [19:0] syms;
    logic [1:0]  got;
    rst = 1'b1; enable_i = 1'b0; d_in = 1'b0;

    // Reset held with enable high, then the reference stream from state 0.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, "reset");
    bits = 10'b1000100110;
    syms = 20'b11_10_11_00_11_10_11_11_01_01;
    for (int i = 0; i < 10; i++)
      add(1'b0, 1'b1, bits[9-i], 1'b1, syms[19-2*i -: 2], "stream");
`ifdef ENC_TAIL_EN
    add(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, "tail1");
    add(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, "tail2");
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, "post_tail");
    add(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "reenable");
`else
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, "idle_hold");
    add(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, "reenable");
`endif

    foreach (vecs[i]) begin
      seq(vecs[i].r, vecs[i].en, vecs[i].d, vecs[i].exp_v, vecs[i].exp_sym, vecs[i].name);
    end

    // Mid-stream reset: restart after bit 4 must encode from state 0.
    seq(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "mr_reset");
    seq(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, "mr_b1");
    seq(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, "mr_b2");
    seq(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, "mr_b3");
    seq(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "mr_b4");
    seq(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, "mr_rst");
    seq(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "mr_r1");
    seq(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, "mr_r2");
    seq(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, "mr_r3");
    seq(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, "mr_r4");
    seq(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, "mr_r5");

`ifdef ENC_TAIL_EN
    // Tail abort: state 11 -> one tail bit (01), re-enable d=1 (00), then a full tail.
    seq(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "ab_reset");
    seq(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, "ab_b1");
    seq(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, "ab_b2");
    seq(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, "ab_tail");
    seq(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, "ab_resume");
    seq(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, "ab_t1");
    seq(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, "ab_t2");
    seq(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, "ab_idle");
    // Reset in the middle of a tail clears it.
    seq(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, "rt_b1");
    seq(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, "rt_t1");
    seq(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "rt_rst");
    seq(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "rt_idle");
`endif

    // Randomized run: expected symbols queued as stimulus is driven, popped on valid_o.
    sb.delete();
    for (int i = 0; i < 10000; i++) begin
      logic r, e, d;
      r = (i == 0) || ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 9) < 7);
      d = 1'($urandom_range(0, 1));
      model_step(r, e, d);
      step(r, e, d);
      check("rnd_valid", 32'(valid_o), 32'(m_v));
      if (valid_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_sb_empty: got symbol %b expected none", d_out);
        end else begin
          got = sb.pop_front();
          check("rnd_sym", 32'(d_out), 32'(got));
        end
      end else if (m_v) begin
        void'(sb.pop_front());
      end
      check("rnd_hold", 32'(d_out), 32'(m_sym));
    end
    check("rnd_sb_drain", 32'(sb.size()), 32'd0);
    $display("random: 10000 cycles applied");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
